// File: rtl/fetch_unit.sv
// fetch_unit: PC generator with a one-line buffer that feeds the IQ one {pc, instr} per cycle. A miss costs one cycle plus cache latency.
// The pc is held while iq_full is high, and a redirect wins in every state. Defining FETCH_PERF_EN adds hit/miss counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'haaaaa000,
  parameter int unsigned LINE_W   = 256
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       ic_addr,
  output logic              ic_read,
  input  logic [LINE_W-1:0] ic_rdata,
  input  logic              ic_resp,
  output logic [63:0]       iq_wdata,
  output logic              iq_enqueue,
  input  logic              iq_full,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       perf_hit_count,
  output logic [31:0]       perf_miss_count
);

  typedef enum logic [1:0] {S_RUN, S_REQ, S_DISCARD} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              lb_valid_q, lb_valid_d;
  logic [26:0]       lb_tag_q, lb_tag_d;
  logic [LINE_W-1:0] lb_data_q;
  logic              hit, fill, enq;

  assign hit = lb_valid_q && (lb_tag_q == pc_q[31:5]);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lb_valid_d = lb_valid_q;
    lb_tag_d   = lb_tag_q;
    fill       = 1'b0;
    enq        = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (hit) begin
          if (!iq_full) begin
            enq  = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A response coinciding with a redirect belongs to the old stream and is dropped.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ic_resp ? S_RUN : S_DISCARD;
        end else if (ic_resp) begin
          fill       = 1'b1;
          lb_valid_d = 1'b1;
          lb_tag_d   = pc_q[31:5];
          state_d    = S_RUN;
        end
      end
      S_DISCARD: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        // The outstanding response is consumed even if a redirect arrives the same cycle.
        if (ic_resp) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lb_valid_q <= lb_valid_d;
      lb_tag_q   <= lb_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      lb_data_q <= ic_rdata;
    end
  end

  assign ic_read    = (state_q == S_REQ);
  assign ic_addr    = {pc_q[31:5], 5'b0};
  assign iq_enqueue = enq;
  assign iq_wdata   = {pc_q, lb_data_q[{pc_q[4:2], 5'b0} +: 32]};

`ifdef FETCH_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (enq) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == S_RUN && state_d == S_REQ) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign perf_hit_count  = hit_cnt_q;
  assign perf_miss_count = miss_cnt_q;
`else
  assign perf_hit_count  = '0;
  assign perf_miss_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a stimulus-side predictor queues the expected {pc, instr} stream.
// A negedge monitor pops and compares every enqueue; a cache model answers requests with address-derived lines.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'haaaaa000;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ic_addr;
  logic         ic_read;
  logic [255:0] ic_rdata;
  logic         ic_resp;
  logic [63:0]  iq_wdata;
  logic         iq_enqueue;
  logic         iq_full;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [31:0]  perf_hit_count, perf_miss_count;

  fetch_unit #(.RESET_PC(RESET_PC), .LINE_W(256)) dut (
    .clk(clk), .rst(rst), .ic_addr(ic_addr), .ic_read(ic_read), .ic_rdata(ic_rdata),
    .ic_resp(ic_resp), .iq_wdata(iq_wdata), .iq_enqueue(iq_enqueue), .iq_full(iq_full),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_hit_count(perf_hit_count), .perf_miss_count(perf_miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: every word is a fixed function of its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h3c5a96e1 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = {a[31:5], 5'b0};
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(base + 32'(i * 4));
    return l;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] pred_pc;

  function automatic void push_next();
    exp_q.push_back({pred_pc, mem_word(pred_pc)});
    pred_pc = pred_pc + 32'd4;
  endfunction

  function automatic void restart(input logic [31:0] p);
    exp_q.delete();
    pred_pc = p;
    for (int i = 0; i < 8; i++) push_next();
  endfunction

  int          enq_cnt = 0, req_cnt = 0, enq_since_rst = 0, req_since_rst = 0;
  int          cyc = 0, first_enq_cyc = 0, eighth_enq_cyc = 0;
  logic [31:0] last_enq_pc, last_req;

  always @(posedge clk) cyc++;

  // Monitor
  always @(negedge clk) begin
    ent_t e;
    if (rst === 1'b1) begin
      if (iq_enqueue === 1'b1) begin
        enq_cnt++;
        enq_since_rst++;
        last_enq_pc = iq_wdata[63:32];
        if (enq_cnt == 1) first_enq_cyc = cyc;
        if (enq_cnt == 8) eighth_enq_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL enq_unexpected: got %h expected no entry", iq_wdata);
        end else begin
          e = exp_q.pop_front();
          check("enq_entry", iq_wdata, e);
          while (exp_q.size() < 4) push_next();
        end
        check("enq_gating", {62'b0, redirect_valid, iq_full}, 64'd0);
      end
      if (ic_read === 1'b1 && !redirect_valid && exp_q.size() > 0)
        check("ic_addr", {32'b0, ic_addr}, {32'b0, exp_q[0].pc[31:5], 5'b0});
    end
  end

  // Cache model: one outstanding request, latency drawn from [lat_lo, lat_hi].
  int          lat_lo = 0, lat_hi = 0, resp_cnt = 0;
  bit          resp_busy = 0;
  logic [31:0] resp_addr;

  always @(negedge clk) begin
    ic_resp = 1'b0;
    if (!resp_busy && ic_read === 1'b1) begin
      resp_busy = 1;
      resp_addr = ic_addr;
      resp_cnt  = int'($urandom_range(lat_hi, lat_lo));
      last_req  = ic_addr;
      req_cnt++;
      req_since_rst++;
    end
    if (resp_busy) begin
      if (resp_cnt == 0) begin
        ic_resp   = 1'b1;
        ic_rdata  = mem_line(resp_addr);
        resp_busy = 0;
      end else begin
        resp_cnt--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    restart(t);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_enq(input int n);
    int t;
    t = 0;
    while (enq_cnt < n && t < 300) begin
      tick();
      t++;
    end
    check("wait_enq_timeout", 64'(enq_cnt >= n), 64'd1);
  endtask

  task automatic wait_req(input int n);
    int t;
    t = 0;
    while (req_cnt < n && t < 300) begin
      tick();
      t++;
    end
    check("wait_req_timeout", 64'(req_cnt >= n), 64'd1);
  endtask

  task automatic wait_read();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (ic_read !== 1'b1 && t < 300);
    check("wait_read_timeout", 64'(ic_read), 64'd1);
  endtask

  task automatic check_perf(input string n, input int hits, input int misses);
`ifdef FETCH_PERF_EN
    check({n, "_perf_hit"}, 64'(perf_hit_count), 64'(hits));
    check({n, "_perf_miss"}, 64'(perf_miss_count), 64'(misses));
`else
    check({n, "_perf_hit"}, 64'(perf_hit_count), 64'd0 & 64'(hits));
    check({n, "_perf_miss"}, 64'(perf_miss_count), 64'd0 & 64'(misses));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int          e0, r0;
    logic [31:0] t, rv;
    rst = 1'b0;
    ic_resp = 1'b0;
    ic_rdata = '0;
    iq_full = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    restart(RESET_PC);
    #12;
    check("rst_ic_read", 64'(ic_read), 64'd0);
    check("rst_iq_enqueue", 64'(iq_enqueue), 64'd0);
    check("rst_ic_addr", 64'(ic_addr), 64'(RESET_PC));
    check_perf("rst", 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Sequential line fetch with 1-cycle cache response.
    wait_enq(8);
    check("line0_req_cnt", 64'(req_cnt), 64'd1);
    check("line0_consecutive", 64'(eighth_enq_cyc - first_enq_cyc), 64'd7);
    wait_req(2);
    check("line1_addr", 64'(last_req), 64'h00000000aaaaa020);
    check("line1_enq_cnt", 64'(enq_cnt), 64'd8);
    check_perf("line1", 8, 2);

    // Queue full mid-line at 0xaaaaa008.
    iq_full = 1'b1;
    e0 = enq_cnt;
    do_redirect(32'haaaaa008);
    repeat (10) tick();
    r0 = req_cnt;
    repeat (5) tick();
    check("full_no_enq", 64'(enq_cnt), 64'(e0));
    check("full_no_req", 64'(req_cnt), 64'(r0));
    check("full_ic_read", 64'(ic_read), 64'd0);
    check("full_pc_line", 64'(ic_addr), 64'h00000000aaaaa000);
    iq_full = 1'b0;
    tick();
    iq_full = 1'b1;
    check("full_resume_pc", 64'(last_enq_pc), 64'h00000000aaaaa008);
    check("full_resume_cnt", 64'(enq_cnt), 64'(e0 + 1));

    // Redirect into the buffered line hits without a cache access.
    iq_full = 1'b0;
    r0 = req_cnt;
    do_redirect(32'haaaaa014);
    lat_lo = 3;
    lat_hi = 3;
    @(negedge clk);
    #1;
    check("redir_hit_enq", 64'(iq_enqueue), 64'd1);
    check("redir_hit_data", iq_wdata, {32'haaaaa014, mem_word(32'haaaaa014)});
    check("redir_hit_no_req", 64'(req_cnt), 64'(r0));

    // Redirect while the request for 0xaaaaa020 is outstanding.
    wait_read();
    check("pending_addr", 64'(last_req), 64'h00000000aaaaa020);
    e0 = enq_cnt;
    r0 = req_cnt;
    @(posedge clk);
    #1;
    do_redirect(32'hbbbb0000);
    wait_req(r0 + 1);
    check("discard_no_enq", 64'(enq_cnt), 64'(e0));
    check("discard_new_addr", 64'(last_req), 64'h00000000bbbb0000);
    wait_enq(e0 + 3);

    // Asynchronous reset during an outstanding miss.
    @(posedge clk);
    #1;
    do_redirect(32'hcccc0000);
    wait_read();
    #2;
    rst = 1'b0;
    restart(RESET_PC);
    enq_since_rst = 0;
    req_since_rst = 0;
    #1;
    check("arst_ic_read", 64'(ic_read), 64'd0);
    check("arst_iq_enqueue", 64'(iq_enqueue), 64'd0);
    check("arst_ic_addr", 64'(ic_addr), 64'(RESET_PC));
    repeat (6) @(negedge clk);
    check_perf("arst", 0, 0);
    rst = 1'b1;
    r0 = req_cnt;
    e0 = enq_cnt;
    wait_req(r0 + 1);
    check("arst_refetch_addr", 64'(last_req), 64'(RESET_PC));
    wait_enq(e0 + 9);

    // Randomized traffic: backpressure, redirects (incl. buffered line and pc wrap), variable latency.
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      iq_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        rv = $urandom();
        case ($urandom_range(0, 3))
          0:       t = {exp_q[0].pc[31:5], rv[4:2], 2'b00};
          1:       t = RESET_PC + {25'b0, rv[6:2], 2'b00};
          2:       t = 32'hffffffe0 + {27'b0, rv[4:2], 2'b00};
          default: t = {rv[31:2], 2'b00};
        endcase
        do_redirect(t);
      end else begin
        tick();
      end
    end
    iq_full = 1'b1;
    repeat (30) tick();
    check_perf("final", enq_since_rst, req_since_rst);
    check("final_activity", 64'(enq_cnt > 200), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
